// File: rtl/aie_trip_latch_if.sv
// Sample/control/status bundle between the limit-check path and the trip latch.
// The master drives samples and controls; the slave (trip latch) returns latched status.
interface aie_trip_latch_if #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
);
  logic                    arm_i;
  logic                    clear_i;
  logic                    strobe_i;
  logic                    valid_n_i;
  logic signed [31:0]      pos_i;
  logic        [CNT_W-1:0] debounce_i;
  logic                    trip_o;
  logic                    pending_o;
  logic        [CNT_W-1:0] fault_cnt_o;
  logic signed [31:0]      first_pos_o;
  logic        [TS_W-1:0]  trip_ts_o;
  logic        [1:0]       state_o;

  modport master (
    output arm_i, clear_i, strobe_i, valid_n_i, pos_i, debounce_i,
    input  trip_o, pending_o, fault_cnt_o, first_pos_o, trip_ts_o, state_o
  );

  modport slave (
    input  arm_i, clear_i, strobe_i, valid_n_i, pos_i, debounce_i,
    output trip_o, pending_o, fault_cnt_o, first_pos_o, trip_ts_o, state_o
  );
endinterface

// File: rtl/aie_trip_latch.sv
// Debounced interlock trip latch: N consecutive out-of-limit samples latch a trip
// together with the first-fault position and trip timestamp until software clears it.
module aie_trip_latch #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  aie_trip_latch_if.slave   bus
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_PENDING  = 2'd2,
    S_TRIPPED  = 2'd3
  } state_t;

  state_t                    state;
  logic                      trip;
  logic                      pending;
  logic        [CNT_W-1:0]   fault_cnt;
  logic signed [31:0]        cand_pos;
  logic signed [31:0]        first_pos;
  logic        [TS_W-1:0]    trip_ts;
  logic        [TS_W-1:0]    ts;

  logic        [CNT_W-1:0]   thr;
  logic        [CNT_W-1:0]   cnt_next;
  logic                      fault;

  // A zero threshold would never be reached by a count that starts at 1.
  assign thr      = (bus.debounce_i == '0) ? CNT_W'(1) : bus.debounce_i;
  assign cnt_next = (&fault_cnt) ? fault_cnt : fault_cnt + CNT_W'(1);
  assign fault    = bus.strobe_i && bus.valid_n_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_DISARMED;
      trip      <= 1'b0;
      pending   <= 1'b0;
      fault_cnt <= '0;
      cand_pos  <= '0;
      first_pos <= '0;
      trip_ts   <= '0;
      ts        <= '0;
    end else begin
      if (bus.strobe_i) ts <= ts + TS_W'(1);

      // Disarm overrides clear and strobe; capture data stays for readout.
      if (!bus.arm_i) begin
        state     <= S_DISARMED;
        trip      <= 1'b0;
        pending   <= 1'b0;
        fault_cnt <= '0;
      end else begin
        unique case (state)
          S_DISARMED: state <= S_ARMED;
          S_ARMED: begin
            if (fault) begin
              fault_cnt <= CNT_W'(1);
              cand_pos  <= bus.pos_i;
              if (thr == CNT_W'(1)) begin
                state     <= S_TRIPPED;
                trip      <= 1'b1;
                trip_ts   <= ts;
                first_pos <= bus.pos_i;
              end else begin
                state   <= S_PENDING;
                pending <= 1'b1;
              end
            end
          end
          S_PENDING: begin
            if (fault) begin
              fault_cnt <= cnt_next;
              if (cnt_next >= thr) begin
                state     <= S_TRIPPED;
                trip      <= 1'b1;
                pending   <= 1'b0;
                trip_ts   <= ts;
                first_pos <= cand_pos;
              end
            end else if (bus.strobe_i) begin
              state     <= S_ARMED;
              pending   <= 1'b0;
              fault_cnt <= '0;
            end
          end
          S_TRIPPED: begin
            if (bus.clear_i) begin
              state     <= S_ARMED;
              trip      <= 1'b0;
              pending   <= 1'b0;
              fault_cnt <= '0;
            end
          end
          default: state <= S_DISARMED;
        endcase
      end
    end
  end

  assign bus.trip_o      = trip;
  assign bus.pending_o   = pending;
  assign bus.fault_cnt_o = fault_cnt;
  assign bus.first_pos_o = first_pos;
  assign bus.trip_ts_o   = trip_ts;
  assign bus.state_o     = state;

endmodule
